// File: rtl/const_stream_pkg.sv
// const_pkg: shared constants and types for the const_stream block.
//   NUM_WORDS    number of snapshot data words per frame
//   IDX_*        word positions within a frame (checksum is the optional 7th)
//   state_e      streaming FSM states
//   cksum_of()   two's-complement checksum so a frame sums to 0 mod 256
package const_pkg;

  localparam int NUM_WORDS = 6;

  localparam logic [2:0] IDX_OT     = 3'd0;
  localparam logic [2:0] IDX_OF     = 3'd1;
  localparam logic [2:0] IDX_O1     = 3'd2;
  localparam logic [2:0] IDX_O2     = 3'd3;
  localparam logic [2:0] IDX_EXPAND = 3'd4;
  localparam logic [2:0] IDX_CUT    = 3'd5;
  localparam logic [2:0] IDX_CKSUM  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  // (256 - sum) mod 256 is just the 8-bit negation of the running sum.
  function automatic logic [7:0] cksum_of(input logic [7:0] sum);
    return 8'd0 - sum;
  endfunction

endpackage

// File: rtl/const_snap_regs.sv
// const_snap_regs: 6x8 snapshot register file.
//   clk, rst      clock, synchronous active-high reset (clears all entries)
//   load          capture all six source values this edge
//   in_ot, in_of  1-bit sources, zero-extended to 8 bits on capture
//   in_o1..in_o_cut 8-bit sources, stored unchanged
//   rd_idx        combinational read index; indices >= NUM_WORDS read as 0
//   rd_data       selected word
module const_snap_regs
  import const_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       in_ot,
  input  logic       in_of,
  input  logic [7:0] in_o1,
  input  logic [7:0] in_o2,
  input  logic [7:0] in_o_expand,
  input  logic [7:0] in_o_cut,
  input  logic [2:0] rd_idx,
  output logic [7:0] rd_data
);

  logic [NUM_WORDS-1:0][7:0] snap_q, snap_d;

  always_comb begin
    snap_d = snap_q;
    if (load) begin
      snap_d[IDX_OT]     = {7'd0, in_ot};
      snap_d[IDX_OF]     = {7'd0, in_of};
      snap_d[IDX_O1]     = in_o1;
      snap_d[IDX_O2]     = in_o2;
      snap_d[IDX_EXPAND] = in_o_expand;
      snap_d[IDX_CUT]    = in_o_cut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) snap_q <= '0;
    else     snap_q <= snap_d;
  end

  // Out-of-range reads (the checksum slot) return 0 rather than aliasing.
  always_comb begin
    rd_data = 8'd0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (rd_idx == 3'(i)) rd_data = snap_q[i];
    end
  end

endmodule

// File: rtl/const_stream.sv
// const_stream: snapshots six constant sources on start and streams them as
// 8-bit words over valid/ready, optionally followed by a checksum word, for
// REPEAT frames per start.
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle request, ignored unless idle
//   in_*          constant sources (ot/of 1 bit, others 8 bit)
//   out_data      current word; out_valid/out_ready handshake
//   out_last      marks final word of each frame
//   out_idx       position of current word in frame
//   busy          high from LOAD through DONE inclusive
//   done          one-cycle pulse after final transfer of final frame
module const_stream
  import const_pkg::*;
#(
  parameter int CKSUM_EN = 1,
  parameter int REPEAT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_ot,
  input  logic       in_of,
  input  logic [7:0] in_o1,
  input  logic [7:0] in_o2,
  input  logic [7:0] in_o_expand,
  input  logic [7:0] in_o_cut,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [2:0] out_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = (CKSUM_EN != 0) ? IDX_CKSUM : IDX_CUT;
  localparam logic [3:0] REPEAT_N = 4'(REPEAT);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] frame_q, frame_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;

  logic       snap_load;
  logic [2:0] rd_idx;
  logic [7:0] rd_data;
  logic [2:0] idx_nxt;

  assign idx_nxt = idx_q + 3'd1;

  const_snap_regs u_snap (
    .clk         (clk),
    .rst         (rst),
    .load        (snap_load),
    .in_ot       (in_ot),
    .in_of       (in_of),
    .in_o1       (in_o1),
    .in_o2       (in_o2),
    .in_o_expand (in_o_expand),
    .in_o_cut    (in_o_cut),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data)
  );

  // Output regs are loaded one cycle ahead: whenever a word is accepted (or
  // the frame starts) the next word is fetched and registered, so a new word
  // appears the cycle after each transfer and holds through any stall.
  // The checksum accumulates each data word as it is presented, so it is
  // complete by the time the checksum slot is reached.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    sum_d     = sum_q;
    data_d    = data_q;
    last_d    = last_q;
    snap_load = 1'b0;
    rd_idx    = IDX_OT;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          snap_load = 1'b1;
          frame_d   = 4'd0;
        end
      end

      LOAD: begin
        // Running sum restarts from zero with the first word folded in.
        state_d = SEND;
        idx_d   = IDX_OT;
        data_d  = rd_data;
        sum_d   = 8'd0 + rd_data;
        last_d  = 1'b0;
      end

      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            frame_d = frame_q + 4'd1;
            idx_d   = IDX_OT;
            last_d  = 1'b0;
            if (frame_q + 4'd1 >= REPEAT_N) begin
              state_d = DONE;
              data_d  = 8'd0;
            end else begin
              // Next frame reuses the same snapshot.
              data_d = rd_data;
              sum_d  = rd_data;
            end
          end else begin
            idx_d  = idx_nxt;
            last_d = (idx_nxt == LAST_IDX);
            if ((CKSUM_EN != 0) && (idx_nxt == IDX_CKSUM)) begin
              data_d = cksum_of(sum_q);
            end else begin
              rd_idx = idx_nxt;
              data_d = rd_data;
              sum_d  = sum_q + rd_data;
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      frame_q <= 4'd0;
      sum_q   <= 8'd0;
      data_q  <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
